exposure_sequencer: RTL
=======================

EXPOSURE_SEQUENCER -- requirements
Module: exposure_sequencer

Interface
REQ-001 Parameter FIELDS, default 4: exposure fields per wafer, range 1..255.
REQ-002 Parameter PULSES_PER_FIELD, default 8: laser pulses per field, range 1..255.
REQ-003 Parameter PULSE_GAP, default 3: idle cycles between pulses in one field, range 1..255.
REQ-004 Parameter STEP_CYCLES, default 16: stage move time in cycles between fields, range 1..255.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port current_process, input, 4: scanner phase code from the scanner FSM; 4'd6 = EXPOSE.
REQ-008 Port interlock_sig, input, 1: high = safety interlock asserted.
REQ-009 Port source_ready, input, 1: high = laser source ready to fire.
REQ-010 Port laser_fire, output, 1: single-cycle pulse request to the laser.
REQ-011 Port stage_step, output, 1: single-cycle request to move the stage to the next field.
REQ-012 Port field_idx, output, 8: current field index, 0-based.
REQ-013 Port pulse_cnt, output, 8: pulses fired in the current field.
REQ-014 Port dose_total, output, 16: pulses fired since the current EXPOSE entry.
REQ-015 Port expose_busy, output, 1: high in WAIT_SRC, FIRE, GAP and STEP.
REQ-016 Port expose_done, output, 1: single-cycle completion pulse.
REQ-017 Port expose_abort, output, 1: level; high while in ABORT.

Function
REQ-018 The state set SHALL be IDLE, WAIT_SRC, FIRE, GAP, STEP, DONE, ABORT, with all state transitions registered.
REQ-019 An EXPOSE entry SHALL be current_process==6 this cycle and !=6 in the previous registered sample.
- In IDLE, an entry clears field_idx, pulse_cnt and dose_total.
- The state is WAIT_SRC on the next edge.
REQ-020 WAIT_SRC SHALL advance to FIRE on the edge where source_ready==1, and SHALL hold indefinitely otherwise.
REQ-021 FIRE SHALL last exactly one cycle.
- laser_fire = (state==FIRE) & ~interlock_sig.
- In that cycle pulse_cnt and dose_total increment; dose_total saturates at 16'hFFFF.
REQ-022 When FIRE is left with a completed field (pulse_cnt reaches PULSES_PER_FIELD):
- Last field (field_idx==FIELDS-1): go to DONE.
- Otherwise: go to STEP.
- Field not complete: go to GAP.
REQ-023 GAP SHALL last exactly PULSE_GAP cycles, then go to WAIT_SRC.
REQ-024 STEP SHALL:
- Assert stage_step in its first cycle only.
- Last exactly STEP_CYCLES cycles.
- On exit, increment field_idx, clear pulse_cnt and go to WAIT_SRC.
REQ-025 DONE SHALL:
- Assert expose_done in its first cycle only.
- Hold field_idx, pulse_cnt and dose_total.
- Return to IDLE when current_process!=6.
REQ-026 From WAIT_SRC, FIRE, GAP or STEP, go to ABORT on the next edge if interlock_sig==1 or current_process!=6.
- interlock_sig high in FIRE suppresses laser_fire (REQ-021) and blocks the counter increments.
REQ-027 When ABORT coincides with another transition condition (field completion, GAP or STEP expiry), ABORT SHALL win.
REQ-028 ABORT SHALL:
- Keep expose_abort high and freeze the counters.
- Go to IDLE only when interlock_sig==0 and current_process!=6.
- Not re-arm until a fresh EXPOSE entry (REQ-019).
REQ-029 When current_process==6 is held continuously after DONE or ABORT, a new sequence SHALL NOT start; only a new entry edge starts one.
REQ-030 At most one laser_fire SHALL occur per FIRE visit; at least PULSE_GAP+2 cycles SHALL separate consecutive laser_fire pulses.

Reset
REQ-031 When reset==0, asynchronously:
- State=IDLE and all outputs 0, including counters.
- The previous-phase sample is cleared to 4'd0.
REQ-032 An assertion of reset mid-sequence SHALL abandon the sequence with no further laser_fire or stage_step. After deassertion, a sequence starts only on a new EXPOSE entry edge.

Verification (bench overrides: FIELDS=2, PULSES_PER_FIELD=3, PULSE_GAP=2, STEP_CYCLES=4)
REQ-033 Nominal: current_process 5->6, source_ready=1 held -> exactly 6 laser_fire, one stage_step after the 3rd fire, one expose_done, final dose_total=6, field_idx=1.
REQ-034 Source stall: source_ready=0 for 20 cycles after entry -> no laser_fire during stall, expose_busy=1, first fire 1 cycle after source_ready rises.
REQ-035 Interlock in FIRE: interlock_sig=1 in the 2nd FIRE cycle -> laser_fire stays 0 that cycle, expose_abort=1 next cycle, dose_total=1. When interlock_sig=0 and current_process=7 -> IDLE, expose_abort=0.
REQ-036 Early exit: current_process 6->7 during STEP -> ABORT next cycle, no further stage_step or laser_fire, then IDLE.
REQ-037 Reset mid-GAP: reset=0 for 3 cycles with current_process=6 held -> all outputs 0. After release, no activity until current_process leaves 6 and re-enters.
REQ-038 Held EXPOSE after DONE: current_process kept at 6 for 50 cycles after expose_done -> no further laser_fire; the 6->0->6 sequence restarts with dose_total reset to 0.

Source files
------------

// File: rtl/exposure_sequencer.sv
// Laser exposure sequencer: fires PULSES_PER_FIELD pulses per field over FIELDS fields,
// stepping the stage between fields and aborting on interlock or early phase exit.
module exposure_sequencer #(
    parameter int unsigned FIELDS           = 4,
    parameter int unsigned PULSES_PER_FIELD = 8,
    parameter int unsigned PULSE_GAP        = 3,
    parameter int unsigned STEP_CYCLES      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  current_process,
    input  logic        interlock_sig,
    input  logic        source_ready,
    output logic        laser_fire,
    output logic        stage_step,
    output logic [7:0]  field_idx,
    output logic [7:0]  pulse_cnt,
    output logic [15:0] dose_total,
    output logic        expose_busy,
    output logic        expose_done,
    output logic        expose_abort
);

    typedef enum logic [2:0] {
        StIdle, StWaitSrc, StFire, StGap, StStep, StDone, StAbort
    } state_e;

    localparam logic [3:0] EXPOSE     = 4'd6;
    localparam logic [7:0] LAST_FIELD = 8'(FIELDS - 1);
    localparam logic [7:0] LAST_PULSE = 8'(PULSES_PER_FIELD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(PULSE_GAP - 1);
    localparam logic [7:0] STEP_LAST  = 8'(STEP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  prev_process_q;
    logic        prev_valid_q;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  field_idx_q, field_idx_d;
    logic [7:0]  pulse_cnt_q, pulse_cnt_d;
    logic [15:0] dose_q, dose_d;

    logic in_expose, entry, abort_req, fire_ok, step_exit;

    // The first sample after reset is not a real "previous" phase, so a phase held at
    // EXPOSE across reset release is not mistaken for a fresh entry.
    assign in_expose = (current_process == EXPOSE);
    assign entry     = in_expose && prev_valid_q && (prev_process_q != EXPOSE);
    assign abort_req = interlock_sig || !in_expose;
    assign fire_ok   = (state_q == StFire) && !interlock_sig;
    assign step_exit = (state_q == StStep) && !abort_req && (timer_q == STEP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            prev_process_q <= 4'd0;
            prev_valid_q   <= 1'b0;
            timer_q        <= 8'd0;
            field_idx_q    <= 8'd0;
            pulse_cnt_q    <= 8'd0;
            dose_q         <= 16'd0;
        end else begin
            state_q        <= state_d;
            prev_process_q <= current_process;
            prev_valid_q   <= 1'b1;
            timer_q        <= timer_d;
            field_idx_q    <= field_idx_d;
            pulse_cnt_q    <= pulse_cnt_d;
            dose_q         <= dose_d;
        end
    end

    // Timer restarts at zero on every state change; zero marks a state's first cycle.
    always_comb begin
        state_d = state_q;
        timer_d = 8'd0;
        unique case (state_q)
            StIdle: begin
                if (entry) state_d = StWaitSrc;
            end
            StWaitSrc: begin
                if (abort_req)         state_d = StAbort;
                else if (source_ready) state_d = StFire;
            end
            StFire: begin
                if (abort_req)                       state_d = StAbort;
                else if (pulse_cnt_q != LAST_PULSE)  state_d = StGap;
                else if (field_idx_q == LAST_FIELD)  state_d = StDone;
                else                                 state_d = StStep;
            end
            StGap: begin
                if (abort_req)               state_d = StAbort;
                else if (timer_q == GAP_LAST) state_d = StWaitSrc;
                else                          timer_d = timer_q + 8'd1;
            end
            StStep: begin
                if (abort_req)                state_d = StAbort;
                else if (timer_q == STEP_LAST) state_d = StWaitSrc;
                else                           timer_d = timer_q + 8'd1;
            end
            StDone: begin
                if (!in_expose) state_d = StIdle;
                else            timer_d = 8'd1;
            end
            StAbort: begin
                if (!interlock_sig && !in_expose) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        field_idx_d = field_idx_q;
        pulse_cnt_d = pulse_cnt_q;
        dose_d      = dose_q;
        if ((state_q == StIdle) && entry) begin
            field_idx_d = 8'd0;
            pulse_cnt_d = 8'd0;
            dose_d      = 16'd0;
        end
        if (fire_ok) begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
            if (dose_q != 16'hFFFF) dose_d = dose_q + 16'd1;
        end
        if (step_exit) begin
            field_idx_d = field_idx_q + 8'd1;
            pulse_cnt_d = 8'd0;
        end
    end

    always_comb begin
        laser_fire   = fire_ok;
        stage_step   = (state_q == StStep) && (timer_q == 8'd0);
        expose_done  = (state_q == StDone) && (timer_q == 8'd0);
        expose_busy  = (state_q == StWaitSrc) || (state_q == StFire) ||
                       (state_q == StGap) || (state_q == StStep);
        expose_abort = (state_q == StAbort);
        field_idx    = field_idx_q;
        pulse_cnt    = pulse_cnt_q;
        dose_total   = dose_q;
    end

endmodule
